// File: rtl/acc_fifo_bridge.sv
// acc_fifo_bridge: accelerator-side end of the router put/get FIFO handshake.
// Channel 0 is the to-accelerator FIFO (router put_req in, acc_pop out).
// Channel 1 is the from-accelerator FIFO (acc_push in, router get_req out).
// Both channels are identical circular buffers with registered 1-cycle pops.
// They share only the sticky error flags and the enable-driven flush.
module acc_fifo_bridge #(
  parameter int DATA_WIDTH = 32,
  parameter int DEPTH      = 16,
  parameter int ADDR_BITS  = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  enable,
  input  logic                  put_req,
  input  logic [DATA_WIDTH-1:0] put_data,
  output logic                  to_full,
  output logic                  to_empty,
  input  logic                  get_req,
  output logic [DATA_WIDTH-1:0] get_data,
  output logic                  get_valid,
  output logic                  from_full,
  output logic                  from_empty,
  input  logic                  acc_pop,
  output logic [DATA_WIDTH-1:0] acc_rd_data,
  output logic                  acc_rd_valid,
  input  logic                  acc_push,
  input  logic [DATA_WIDTH-1:0] acc_wr_data,
  output logic [ADDR_BITS:0]    to_count,
  output logic [ADDR_BITS:0]    from_count,
  output logic                  ovf_err,
  output logic                  unf_err
);

  localparam logic [ADDR_BITS:0] FULL_COUNT = (ADDR_BITS+1)'(DEPTH);

  // Per-channel request/data routing: index 0 = to-FIFO, 1 = from-FIFO.
  logic [1:0]            wr_req;
  logic [1:0]            rd_req;
  logic [DATA_WIDTH-1:0] wr_data  [2];
  logic [1:0]            full_v;
  logic [1:0]            empty_v;
  logic [1:0]            rd_valid_v;
  logic [DATA_WIDTH-1:0] rd_data_v [2];
  logic [ADDR_BITS:0]    count_v  [2];
  logic [1:0]            ovf_hit;
  logic [1:0]            unf_hit;

  assign wr_req     = {acc_push, put_req};
  assign rd_req     = {get_req, acc_pop};
  assign wr_data[0] = put_data;
  assign wr_data[1] = acc_wr_data;

  for (genvar c = 0; c < 2; c++) begin : g_fifo
    logic [DATA_WIDTH-1:0] mem [DEPTH];
    logic [ADDR_BITS-1:0]  wr_ptr;
    logic [ADDR_BITS-1:0]  rd_ptr;
    logic [ADDR_BITS:0]    count;
    logic [DATA_WIDTH-1:0] rd_data;
    logic                  rd_valid;
    logic                  full;
    logic                  empty;
    logic                  wr_acc;
    logic                  rd_acc;

    // Flags come from the registered count, so they show post-edge state.
    assign full   = (count == FULL_COUNT);
    assign empty  = (count == '0);
    // A read never frees room for a same-cycle write, and a write is never
    // visible to a same-cycle read (no fall-through).
    assign wr_acc = enable & wr_req[c] & ~full;
    assign rd_acc = enable & rd_req[c] & ~empty;

    assign ovf_hit[c]    = enable & wr_req[c] & full;
    assign unf_hit[c]    = enable & rd_req[c] & empty;
    assign full_v[c]     = full;
    assign empty_v[c]    = empty;
    assign count_v[c]    = count;
    assign rd_data_v[c]  = rd_data;
    assign rd_valid_v[c] = rd_valid;

    // Pointer and occupancy tracking; flush clears them while enable is low.
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
        wr_ptr <= '0;
        rd_ptr <= '0;
        count  <= '0;
      end else if (!enable) begin
        wr_ptr <= '0;
        rd_ptr <= '0;
        count  <= '0;
      end else begin
        if (wr_acc) wr_ptr <= wr_ptr + 1'b1;
        if (rd_acc) rd_ptr <= rd_ptr + 1'b1;
        case ({wr_acc, rd_acc})
          2'b10:   count <= count + 1'b1;
          2'b01:   count <= count - 1'b1;
          default: count <= count;
        endcase
      end
    end

    // Storage array write port.
    // NOTE: the storage array has no reset; occupancy tracking makes stale
    // entries unreachable, and leaving it unreset lets it map to RAM.
    always_ff @(posedge clk) begin
      if (wr_acc) mem[wr_ptr] <= wr_data[c];
    end

    // Registered pop data held until the next accepted read, plus valid pulse.
    always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
        rd_data  <= '0;
        rd_valid <= 1'b0;
      end else begin
        rd_valid <= rd_acc;
        if (rd_acc) rd_data <= mem[rd_ptr];
      end
    end
  end

  // Sticky overflow/underflow flags shared by both channels, cleared on flush.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      ovf_err <= 1'b0;
      unf_err <= 1'b0;
    end else if (!enable) begin
      ovf_err <= 1'b0;
      unf_err <= 1'b0;
    end else begin
      if (|ovf_hit) ovf_err <= 1'b1;
      if (|unf_hit) unf_err <= 1'b1;
    end
  end

  assign to_full      = full_v[0];
  assign to_empty     = empty_v[0];
  assign to_count     = count_v[0];
  assign acc_rd_data  = rd_data_v[0];
  assign acc_rd_valid = rd_valid_v[0];
  assign from_full    = full_v[1];
  assign from_empty   = empty_v[1];
  assign from_count   = count_v[1];
  assign get_data     = rd_data_v[1];
  assign get_valid    = rd_valid_v[1];

endmodule

// File: tb/tb_acc_fifo_bridge.sv
// Directed self-checking bench for acc_fifo_bridge.
// Inputs change 1 time unit after a rising edge; outputs are checked there too.
module tb_acc_fifo_bridge;

  localparam int DW = 32;
  localparam int AB = 4;

  logic          clk = 1'b0;
  logic          reset;
  logic          enable;
  logic          put_req;
  logic [DW-1:0] put_data;
  logic          to_full;
  logic          to_empty;
  logic          get_req;
  logic [DW-1:0] get_data;
  logic          get_valid;
  logic          from_full;
  logic          from_empty;
  logic          acc_pop;
  logic [DW-1:0] acc_rd_data;
  logic          acc_rd_valid;
  logic          acc_push;
  logic [DW-1:0] acc_wr_data;
  logic [AB:0]   to_count;
  logic [AB:0]   from_count;
  logic          ovf_err;
  logic          unf_err;

  int n_cmp = 0;
  int n_err = 0;

  acc_fifo_bridge #(.DATA_WIDTH(DW), .DEPTH(16), .ADDR_BITS(AB)) dut (
    .clk          (clk),
    .reset        (reset),
    .enable       (enable),
    .put_req      (put_req),
    .put_data     (put_data),
    .to_full      (to_full),
    .to_empty     (to_empty),
    .get_req      (get_req),
    .get_data     (get_data),
    .get_valid    (get_valid),
    .from_full    (from_full),
    .from_empty   (from_empty),
    .acc_pop      (acc_pop),
    .acc_rd_data  (acc_rd_data),
    .acc_rd_valid (acc_rd_valid),
    .acc_push     (acc_push),
    .acc_wr_data  (acc_wr_data),
    .to_count     (to_count),
    .from_count   (from_count),
    .ovf_err      (ovf_err),
    .unf_err      (unf_err)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    reset = 1'b0; enable = 1'b0;
    put_req = 1'b0; put_data = '0; get_req = 1'b0;
    acc_pop = 1'b0; acc_push = 1'b0; acc_wr_data = '0;
    #12;
    check("rst_to_empty",   32'(to_empty), 32'd1);
    check("rst_from_empty", 32'(from_empty), 32'd1);
    check("rst_to_full",    32'(to_full), 32'd0);
    check("rst_from_full",  32'(from_full), 32'd0);
    check("rst_get_data",   get_data, 32'd0);
    check("rst_acc_data",   acc_rd_data, 32'd0);
    check("rst_to_count",   32'(to_count), 32'd0);
    check("rst_errs",       {30'd0, ovf_err, unf_err}, 32'd0);
    @(negedge clk);
    reset = 1'b1; enable = 1'b1;
    tick();

    // Three puts, then three pops with one-cycle latency.
    put_req = 1'b1;
    put_data = 32'hA; tick();
    put_data = 32'hB; tick();
    put_data = 32'hC; tick();
    put_req = 1'b0;
    check("put3_count", 32'(to_count), 32'd3);
    check("put3_empty", 32'(to_empty), 32'd0);
    acc_pop = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      check("pop3_valid", 32'(acc_rd_valid), 32'd1);
      check("pop3_data", acc_rd_data, 32'hA + 32'(i));
    end
    acc_pop = 1'b0;
    tick();
    check("pop3_valid_off", 32'(acc_rd_valid), 32'd0);
    check("pop3_hold", acc_rd_data, 32'hC);
    check("pop3_empty", 32'(to_empty), 32'd1);

    // From-FIFO: read while empty, then push two and get them back.
    get_req = 1'b1; tick(); get_req = 1'b0;
    check("unf_set", 32'(unf_err), 32'd1);
    check("unf_no_valid", 32'(get_valid), 32'd0);
    acc_push = 1'b1;
    acc_wr_data = 32'h11; tick();
    acc_wr_data = 32'h22; tick();
    acc_push = 1'b0;
    check("from_count2", 32'(from_count), 32'd2);
    get_req = 1'b1;
    tick();
    check("get1_valid", 32'(get_valid), 32'd1);
    check("get1_data", get_data, 32'h11);
    tick();
    check("get2_data", get_data, 32'h22);
    get_req = 1'b0;
    tick();
    check("from_empty", 32'(from_empty), 32'd1);
    check("get_valid_off", 32'(get_valid), 32'd0);

    // Fill to 16, overflow with 0xDEAD, then flush.
    put_req = 1'b1;
    for (int i = 0; i < 16; i++) begin
      put_data = 32'h100 + 32'(i);
      tick();
    end
    check("fill_full", 32'(to_full), 32'd1);
    check("fill_count", 32'(to_count), 32'd16);
    check("fill_no_ovf", 32'(ovf_err), 32'd0);
    put_data = 32'hDEAD; tick();
    put_req = 1'b0;
    check("ovf_set", 32'(ovf_err), 32'd1);
    check("ovf_count", 32'(to_count), 32'd16);
    enable = 1'b0; tick(); enable = 1'b1;
    check("flush1_count", 32'(to_count), 32'd0);
    check("flush1_errs", {30'd0, ovf_err, unf_err}, 32'd0);

    // Refill, then put+pop while full: put dropped, count 16 -> 15.
    put_req = 1'b1;
    for (int i = 0; i < 16; i++) begin
      put_data = 32'h200 + 32'(i);
      tick();
    end
    put_data = 32'hBEEF; acc_pop = 1'b1;
    tick();
    put_req = 1'b0;
    check("fullrw_ovf", 32'(ovf_err), 32'd1);
    check("fullrw_count", 32'(to_count), 32'd15);
    check("fullrw_data", acc_rd_data, 32'h200);
    for (int i = 1; i < 16; i++) begin
      tick();
      check("drain_data", acc_rd_data, 32'h200 + 32'(i));
    end
    check("drain_empty", 32'(to_empty), 32'd1);
    tick();
    acc_pop = 1'b0;
    check("empty_pop_valid", 32'(acc_rd_valid), 32'd0);
    check("empty_pop_hold", acc_rd_data, 32'h20F);

    // Count 5, then 20 simultaneous put+pop cycles across pointer wrap.
    put_req = 1'b1;
    for (int i = 0; i < 5; i++) begin
      put_data = 32'h300 + 32'(i);
      tick();
    end
    acc_pop = 1'b1;
    for (int i = 0; i < 20; i++) begin
      put_data = 32'h305 + 32'(i);
      tick();
      check("wrap_data", acc_rd_data, 32'h300 + 32'(i));
      check("wrap_count", 32'(to_count), 32'd5);
    end
    put_req = 1'b0;
    for (int i = 0; i < 5; i++) begin
      tick();
      check("wrap_drain", acc_rd_data, 32'h314 + 32'(i));
    end
    acc_pop = 1'b0;

    // Load 7 words in each FIFO, then a one-cycle flush with requests active.
    put_req = 1'b1; acc_push = 1'b1;
    for (int i = 0; i < 7; i++) begin
      put_data = 32'h400 + 32'(i);
      acc_wr_data = 32'h500 + 32'(i);
      tick();
    end
    acc_push = 1'b0;
    check("load7_to", 32'(to_count), 32'd7);
    check("load7_from", 32'(from_count), 32'd7);
    enable = 1'b0; get_req = 1'b1; acc_pop = 1'b1;
    tick();
    check("flush_to_count", 32'(to_count), 32'd0);
    check("flush_from_count", 32'(from_count), 32'd0);
    check("flush_empties", {30'd0, to_empty, from_empty}, 32'd3);
    check("flush_errs", {30'd0, ovf_err, unf_err}, 32'd0);
    check("flush_get_hold", get_data, 32'h22);
    check("flush_valids", {30'd0, get_valid, acc_rd_valid}, 32'd0);

    // Enable rises with put_req already high: accepted in that cycle.
    enable = 1'b1; get_req = 1'b0; acc_pop = 1'b0;
    put_data = 32'h600;
    tick();
    check("enable_rise_put", 32'(to_count), 32'd1);

    // Reset asserted mid-burst takes effect without a clock edge.
    put_data = 32'h601; acc_pop = 1'b1;
    tick();
    check("burst_valid", 32'(acc_rd_valid), 32'd1);
    check("burst_data", acc_rd_data, 32'h600);
    #3 reset = 1'b0;
    #1;
    check("arst_to_count", 32'(to_count), 32'd0);
    check("arst_empties", {30'd0, to_empty, from_empty}, 32'd3);
    check("arst_acc_data", acc_rd_data, 32'd0);
    check("arst_acc_valid", 32'(acc_rd_valid), 32'd0);
    check("arst_get_data", get_data, 32'd0);
    put_req = 1'b0; acc_pop = 1'b0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
